zephyr_cosim_txn_arb: RTL

Round-robin arbiter and sequencer sharing a single memory-mapped request channel of the Zephyr co-simulation bridge between N_REQ requesters, e.g. the cosim CPU port and testbench DMA agents. Accepts one request at a time and drives it downstream. Holds the grant until the downstream response returns, then routes the response to the originating requester. Sits between the requesters and the tblink_rpc-backed bus bridge inside the cosim testbench.

---
 rtl/zephyr_cosim_txn_arb.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/zephyr_cosim_txn_arb.sv
// Round-robin arbiter/sequencer sharing one cosim request channel between N_REQ requesters.
// Optional response watchdog enabled by defining ZEPHYR_COSIM_ARB_TIMEOUT_EN.
module zephyr_cosim_txn_arb #(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0]                 req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             m_req_valid,
  input  logic                             m_req_ready,
  output logic                             m_write,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  input  logic                             m_rsp_valid,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_err,
  output logic [GW-1:0]                    grant_id,
  output logic                             busy,
  output logic                             tmo_flag
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic                    m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    win_found;
  logic [GW-1:0]           win_idx;

`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0]           tmo_cnt_q, tmo_cnt_d;
  logic                    tmo_flag_q, tmo_flag_d;
`endif

  // First valid requester strictly after the last served one, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned cand;
      cand = (32'(rr_ptr_q) + k) % N_REQ;
      if (!win_found && req_valid[GW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == S_IDLE) && win_found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    m_write_d   = m_write_q;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_flag_d  = tmo_flag_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d   = win_idx;
          m_write_d = req_write[win_idx];
          m_addr_d  = req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_d = req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (m_req_ready) begin
          state_d = S_WAIT;
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      S_WAIT: begin
        if (m_rsp_valid) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d          = m_rdata;
          rsp_err_d            = m_err;
          rr_ptr_d             = grant_q;
          state_d              = S_IDLE;
        end
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
        // A real response on the expiry cycle takes priority over the watchdog.
        else if (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          tmo_flag_d           = 1'b1;
          rr_ptr_d             = grant_q;
          state_d              = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= GW'(N_REQ - 1);
      grant_q     <= '0;
      m_write_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      tmo_flag_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      m_write_q   <= m_write_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_flag_q  <= tmo_flag_d;
`endif
    end
  end

  assign m_req_valid = (state_q == S_ISSUE);
  assign m_write     = m_write_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != S_IDLE);
`ifdef ZEPHYR_COSIM_ARB_TIMEOUT_EN
  assign tmo_flag    = tmo_flag_q;
`else
  assign tmo_flag    = 1'b0;
`endif

endmodule
